// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: state encoding, NOP opcode,
// instruction field positions and default widths.
package fetch_unit_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    localparam logic [3:0] OP_NOP = 4'h0;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef logic [0:0] state_t;
    localparam state_t S_REQ  = 1'b0;
    localparam state_t S_EXEC = 1'b1;

endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory req/ack fetch interface; master is the fetch unit.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ack;
    logic [INSTR_W-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/fetch_pc.sv
// Program counter: reset value, jump load, wrapping increment, hold.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_advance,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc <= RESET_PC;
        end else if (i_advance) begin
            r_pc <= i_load ? i_load_addr : r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FSM, instruction register and PC update.
// Optional stall-cycle counter enabled by the FETCH_STALL_CNT_EN macro.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    fetch_unit_if.master      imem,
    input  logic              stall_i,
    input  logic              en_jmp_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic              instr_valid_o,
    output logic [3:0]        opcode_o,
    output logic [3:0]        reg_o,
    output logic [7:0]        imm_o,
    output logic [ADDR_W-1:0] pc_o
`ifdef FETCH_STALL_CNT_EN
   ,output logic [15:0]       stall_cnt_o
`endif
);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic               w_exec;
    logic               w_advance;
    logic [ADDR_W-1:0]  w_pc;

    assign w_exec    = (r_state == S_EXEC);
    assign w_advance = w_exec && !stall_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_REQ;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem.ack) begin
                        r_ir    <= imem.data;
                        r_state <= S_EXEC;
                    end
                end
                default: begin
                    if (!stall_i) begin
                        r_state <= S_REQ;
                    end
                end
            endcase
        end
    end

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_advance   (w_advance),
        .i_load      (en_jmp_i),
        .i_load_addr (jmp_addr_i),
        .o_pc        (w_pc)
    );

    assign imem.req  = !w_exec;
    assign imem.addr = w_pc;
    assign pc_o      = w_pc;

    // Outside execute the controller must see a NOP with zeroed fields
    assign instr_valid_o = w_exec;
    assign opcode_o      = w_exec ? r_ir[OPC_MSB:OPC_LSB] : OP_NOP;
    assign reg_o         = w_exec ? r_ir[REG_MSB:REG_LSB] : 4'h0;
    assign imm_o         = w_exec ? r_ir[IMM_MSB:IMM_LSB] : 8'h00;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = w_exec ? stall_i : !imem.ack;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_inc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic       clk_i;
    logic       rst_n_i;
    logic       stall_i;
    logic       en_jmp_i;
    logic [7:0] jmp_addr_i;
    logic       instr_valid_o;
    logic [3:0] opcode_o;
    logic [3:0] reg_o;
    logic [7:0] imm_o;
    logic [7:0] pc_o;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int unsigned n_vec;
    int unsigned n_bad;

    fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) imem ();

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem          (imem.master),
        .stall_i       (stall_i),
        .en_jmp_i      (en_jmp_i),
        .jmp_addr_i    (jmp_addr_i),
        .instr_valid_o (instr_valid_o),
        .opcode_o      (opcode_o),
        .reg_o         (reg_o),
        .imm_o         (imm_o),
        .pc_o          (pc_o)
`ifdef FETCH_STALL_CNT_EN
       ,.stall_cnt_o   (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [7:0] addr);
        check({tag, " req"},    32'(imem.req), 32'd1);
        check({tag, " addr"},   32'(imem.addr), 32'(addr));
        check({tag, " valid"},  32'(instr_valid_o), 32'd0);
        check({tag, " opcode"}, 32'(opcode_o), 32'(OP_NOP));
        check({tag, " reg"},    32'(reg_o), 32'd0);
        check({tag, " imm"},    32'(imm_o), 32'd0);
    endtask

    task automatic check_exec(input string tag, input logic [15:0] d, input logic [7:0] pc);
        check({tag, " valid"},  32'(instr_valid_o), 32'd1);
        check({tag, " req"},    32'(imem.req), 32'd0);
        check({tag, " opcode"}, 32'(opcode_o), 32'(d[15:12]));
        check({tag, " reg"},    32'(reg_o), 32'(d[11:8]));
        check({tag, " imm"},    32'(imm_o), 32'(d[7:0]));
        check({tag, " pc"},     32'(pc_o), 32'(pc));
    endtask

    // One instruction: waits no-ack cycles, fetch, stalls execute cycles, then advance
    task automatic instr(input string tag, input logic [7:0] addr, input logic [15:0] d,
                         input int unsigned waits, input int unsigned stalls,
                         input logic jmp, input logic [7:0] target, input logic [7:0] next);
        check_idle({tag, " req0"}, addr);
        for (int unsigned i = 0; i < waits; i++) begin
            imem.ack = 1'b0;
            step();
            check_idle({tag, " wait"}, addr);
        end
        imem.ack  = 1'b1;
        imem.data = d;
        step();
        imem.ack  = 1'b1;
        imem.data = 16'hDEAD;
        check_exec({tag, " exec"}, d, addr);
        for (int unsigned i = 0; i < stalls; i++) begin
            stall_i    = 1'b1;
            en_jmp_i   = i[0];
            jmp_addr_i = 8'h99;
            step();
            check_exec({tag, " stall"}, d, addr);
        end
        stall_i    = 1'b0;
        en_jmp_i   = jmp;
        jmp_addr_i = target;
        step();
        en_jmp_i   = 1'b0;
        imem.ack   = 1'b0;
        check_idle({tag, " next"}, next);
        check({tag, " pc_next"}, 32'(pc_o), 32'(next));
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        rst_n_i    = 1'b0;
        stall_i    = 1'b0;
        en_jmp_i   = 1'b0;
        jmp_addr_i = 8'h00;
        imem.ack   = 1'b0;
        imem.data  = 16'h0000;
        step();
        step();
        check_idle("reset", 8'h00);
        check("reset pc", 32'(pc_o), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("reset cnt", 32'(stall_cnt_o), 32'd0);
`endif
        rst_n_i = 1'b1;

        instr("zw0",   8'h00, 16'h1234, 0, 0, 1'b0, 8'h77, 8'h01);
        instr("jmp5",  8'h01, 16'hA540, 0, 0, 1'b1, 8'h05, 8'h05);
`ifdef FETCH_STALL_CNT_EN
        check("cnt zero-wait", 32'(stall_cnt_o), 32'd0);
`endif
        instr("wait3", 8'h05, 16'h7F12, 3, 0, 1'b1, 8'h40, 8'h40);
`ifdef FETCH_STALL_CNT_EN
        check("cnt wait3", 32'(stall_cnt_o), 32'd3);
`endif
        instr("jmpFF", 8'h40, 16'h2000, 0, 0, 1'b1, 8'hFF, 8'hFF);
        instr("wrap",  8'hFF, 16'h3311, 0, 0, 1'b0, 8'h55, 8'h00);
        instr("stall", 8'h00, 16'h4ABC, 0, 4, 1'b0, 8'h66, 8'h01);
`ifdef FETCH_STALL_CNT_EN
        check("cnt stall4", 32'(stall_cnt_o), 32'd7);
`endif
        instr("jmp22", 8'h01, 16'h0000, 0, 0, 1'b1, 8'h22, 8'h22);

        // Enter execute at PC 0x22, then reset asynchronously mid-cycle
        imem.ack  = 1'b1;
        imem.data = 16'h5566;
        step();
        imem.ack  = 1'b0;
        check_exec("pre-rst", 16'h5566, 8'h22);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_idle("async rst", 8'h00);
        check("async rst pc", 32'(pc_o), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("async rst cnt", 32'(stall_cnt_o), 32'd0);
`endif
        step();
        // Ack present in the release cycle is a normal fetch of RESET_PC
        imem.ack  = 1'b1;
        imem.data = 16'h9876;
        rst_n_i   = 1'b1;
        step();
        imem.ack  = 1'b0;
        check_exec("rel ack", 16'h9876, 8'h00);
        step();
        check_idle("rel next", 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
